// File: rtl/rob_xcpt_pkg.sv
// Shared core definitions for the ROB exception tracker:
// exception codes, writeback record layout and ROB sizing.
package rob_xcpt_pkg;

  localparam int ROB_ENTRIES = 8;
  localparam int ROB_IDX_W   = 3;

  localparam int XI_W        = 68;
  localparam int XI_VALID    = 67;
  localparam int XI_ADDR_LSB = 35;
  localparam int XI_PC_LSB   = 3;
  localparam int XI_TYPE_LSB = 0;

  typedef enum logic [2:0] {
    XT_ITLB_MISS     = 3'b000,
    XT_FETCH_BUS_ERR = 3'b001,
    XT_ILLEGAL_INSTR = 3'b010,
    XT_OVERFLOW      = 3'b011,
    XT_DTLB_MISS     = 3'b100,
    XT_CACHE_BUS_ERR = 3'b101,
    XT_CACHE_ADDR    = 3'b110
  } xcpt_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_FLUSH,
    ST_WAIT_ACK
  } xt_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] pc;
    logic [2:0]  typ;
  } xcpt_rec_t;

  function automatic xcpt_rec_t unpack_info(input logic [XI_W-1:0] info);
    xcpt_rec_t rec;
    rec.addr = info[XI_ADDR_LSB +: 32];
    rec.pc   = info[XI_PC_LSB +: 32];
    rec.typ  = info[XI_TYPE_LSB +: 3];
    return rec;
  endfunction

endpackage

// File: rtl/rob_xcpt_tracker_age.sv
// Program-order age compare of two ROB ids relative to the head.
// Age wraps modulo the ROB size; smaller age is older.
module rob_age_compare
  import rob_xcpt_pkg::*;
#(
  parameter int IDX_W = ROB_IDX_W
) (
  input  logic [IDX_W-1:0] i_a_id,
  input  logic [IDX_W-1:0] i_b_id,
  input  logic [IDX_W-1:0] i_head_id,
  output logic             o_b_older,
  output logic             o_b_not_younger
);

  logic [IDX_W-1:0] w_age_a;
  logic [IDX_W-1:0] w_age_b;

  assign w_age_a         = i_a_id - i_head_id;
  assign w_age_b         = i_b_id - i_head_id;
  assign o_b_older       = w_age_b < w_age_a;
  assign o_b_not_younger = w_age_b <= w_age_a;

endmodule

// File: rtl/rob_xcpt_tracker.sv
// Keeps the oldest writeback exception, blocks retire at the head,
// then flushes and presents the record until fetch/CSR acks it.
module rob_xcpt_tracker
  import rob_xcpt_pkg::*;
#(
  parameter int          ROB_ENTRIES     = 8,
  parameter int          ROB_IDX_W       = 3,
  parameter logic [31:0] XCPT_HANDLER_PC = 32'h0000_2000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alu_wb_valid,
  input  logic [ROB_IDX_W-1:0] alu_rob_id,
  input  logic [XI_W-1:0]      alu_rob_xcpt_info,
  input  logic                 mul_wb_valid,
  input  logic [ROB_IDX_W-1:0] mul_rob_id,
  input  logic [XI_W-1:0]      mul_rob_xcpt_info,
  input  logic                 cache_wb_valid,
  input  logic [ROB_IDX_W-1:0] cache_rob_id,
  input  logic [XI_W-1:0]      cache_rob_xcpt_info,
  input  logic                 rob_head_valid,
  input  logic [ROB_IDX_W-1:0] rob_head_id,
  input  logic                 xcpt_ack,
  output logic                 rob_retire_block,
  output logic                 xcpt_flush,
  output logic                 xcpt_valid,
  output logic [2:0]           xcpt_type,
  output logic [31:0]          xcpt_addr,
  output logic [31:0]          xcpt_pc,
  output logic [ROB_IDX_W-1:0] xcpt_rob_id,
  output logic [31:0]          xcpt_handler_pc
);

  if (ROB_ENTRIES != (1 << ROB_IDX_W)) begin : g_bad_cfg
    $error("ROB_ENTRIES must equal 2**ROB_IDX_W");
  end

  xt_state_e            r_state;
  xt_state_e            w_state_nx;
  xcpt_rec_t            r_rec;
  logic [ROB_IDX_W-1:0] r_id;

  logic w_alu_c;
  logic w_mul_c;
  logic w_cache_c;
  assign w_alu_c   = alu_wb_valid & alu_rob_xcpt_info[XI_VALID];
  assign w_mul_c   = mul_wb_valid & mul_rob_xcpt_info[XI_VALID];
  assign w_cache_c = cache_wb_valid & cache_rob_xcpt_info[XI_VALID];

  logic w_mul_older;
  logic w_mul_ge_alu;
  rob_age_compare #(.IDX_W(ROB_IDX_W)) u_cmp_am (
    .i_a_id          (alu_rob_id),
    .i_b_id          (mul_rob_id),
    .i_head_id       (rob_head_id),
    .o_b_older       (w_mul_older),
    .o_b_not_younger (w_mul_ge_alu)
  );

  logic                 w_s1_sel_mul;
  logic                 w_s1_c;
  logic [ROB_IDX_W-1:0] w_s1_id;
  logic [XI_W-1:0]      w_s1_info;
  assign w_s1_sel_mul = w_mul_c & (~w_alu_c | w_mul_ge_alu);
  assign w_s1_c       = w_alu_c | w_mul_c;
  assign w_s1_id      = w_s1_sel_mul ? mul_rob_id : alu_rob_id;
  assign w_s1_info    = w_s1_sel_mul ? mul_rob_xcpt_info
                                     : alu_rob_xcpt_info;

  logic w_cache_older;
  logic w_cache_ge_s1;
  rob_age_compare #(.IDX_W(ROB_IDX_W)) u_cmp_sc (
    .i_a_id          (w_s1_id),
    .i_b_id          (cache_rob_id),
    .i_head_id       (rob_head_id),
    .o_b_older       (w_cache_older),
    .o_b_not_younger (w_cache_ge_s1)
  );

  logic                 w_sel_cache;
  logic                 w_cand_c;
  logic [ROB_IDX_W-1:0] w_cand_id;
  logic [XI_W-1:0]      w_cand_info;
  assign w_sel_cache = w_cache_c & (~w_s1_c | w_cache_ge_s1);
  assign w_cand_c    = w_s1_c | w_cache_c;
  assign w_cand_id   = w_sel_cache ? cache_rob_id : w_s1_id;
  assign w_cand_info = w_sel_cache ? cache_rob_xcpt_info : w_s1_info;

  logic w_cand_older;
  logic w_cand_ge_st;
  rob_age_compare #(.IDX_W(ROB_IDX_W)) u_cmp_st (
    .i_a_id          (r_id),
    .i_b_id          (w_cand_id),
    .i_head_id       (rob_head_id),
    .o_b_older       (w_cand_older),
    .o_b_not_younger (w_cand_ge_st)
  );

  logic w_head_hit;
  logic w_load;
  logic w_clear;
  assign w_head_hit = rob_head_valid & (rob_head_id == r_id);
  assign w_load  = ((r_state == ST_IDLE) & w_cand_c)
                 | ((r_state == ST_PENDING) & ~w_head_hit
                    & w_cand_c & w_cand_older);
  assign w_clear = ((r_state == ST_FLUSH) | (r_state == ST_WAIT_ACK))
                 & xcpt_ack;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE:     if (w_cand_c) w_state_nx = ST_PENDING;
      ST_PENDING:  if (w_head_hit) w_state_nx = ST_FLUSH;
      ST_FLUSH:    w_state_nx = xcpt_ack ? ST_IDLE : ST_WAIT_ACK;
      ST_WAIT_ACK: if (xcpt_ack) w_state_nx = ST_IDLE;
      default:     w_state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    xcpt_flush = 1'b0;
    xcpt_valid = 1'b0;
    unique case (r_state)
      ST_FLUSH: begin
        xcpt_flush = 1'b1;
        xcpt_valid = 1'b1;
      end
      ST_WAIT_ACK: xcpt_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rec <= '0;
      r_id  <= '0;
    end else if (w_clear) begin
      r_rec <= '0;
      r_id  <= '0;
    end else if (w_load) begin
      r_rec <= unpack_info(w_cand_info);
      r_id  <= w_cand_id;
    end
  end

  // Raw candidates also block, so the head cannot slip past a
  // faulting writeback in the same cycle it is captured.
  logic w_wb_hit;
  assign w_wb_hit = (w_alu_c & (alu_rob_id == rob_head_id))
                  | (w_mul_c & (mul_rob_id == rob_head_id))
                  | (w_cache_c & (cache_rob_id == rob_head_id));

  assign rob_retire_block = ((r_state != ST_IDLE)
                             & (rob_head_id == r_id))
                          | (rob_head_valid & w_wb_hit);

  assign xcpt_type       = r_rec.typ;
  assign xcpt_addr       = r_rec.addr;
  assign xcpt_pc         = r_rec.pc;
  assign xcpt_rob_id     = r_id;
  assign xcpt_handler_pc = XCPT_HANDLER_PC;

endmodule

// File: tb/tb_rob_xcpt_tracker.sv
// Directed checks of capture, oldest-select, flush and ack
// sequencing of rob_xcpt_tracker.
module tb_rob_xcpt_tracker;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_wb_valid, mul_wb_valid, cache_wb_valid;
  logic [2:0]  alu_rob_id, mul_rob_id, cache_rob_id;
  logic [67:0] alu_rob_xcpt_info, mul_rob_xcpt_info;
  logic [67:0] cache_rob_xcpt_info;
  logic        rob_head_valid;
  logic [2:0]  rob_head_id;
  logic        xcpt_ack;
  logic        rob_retire_block, xcpt_flush, xcpt_valid;
  logic [2:0]  xcpt_type;
  logic [31:0] xcpt_addr, xcpt_pc, xcpt_handler_pc;
  logic [2:0]  xcpt_rob_id;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  rob_xcpt_tracker dut (
    .clock               (clock),
    .reset               (reset),
    .alu_wb_valid        (alu_wb_valid),
    .alu_rob_id          (alu_rob_id),
    .alu_rob_xcpt_info   (alu_rob_xcpt_info),
    .mul_wb_valid        (mul_wb_valid),
    .mul_rob_id          (mul_rob_id),
    .mul_rob_xcpt_info   (mul_rob_xcpt_info),
    .cache_wb_valid      (cache_wb_valid),
    .cache_rob_id        (cache_rob_id),
    .cache_rob_xcpt_info (cache_rob_xcpt_info),
    .rob_head_valid      (rob_head_valid),
    .rob_head_id         (rob_head_id),
    .xcpt_ack            (xcpt_ack),
    .rob_retire_block    (rob_retire_block),
    .xcpt_flush          (xcpt_flush),
    .xcpt_valid          (xcpt_valid),
    .xcpt_type           (xcpt_type),
    .xcpt_addr           (xcpt_addr),
    .xcpt_pc             (xcpt_pc),
    .xcpt_rob_id         (xcpt_rob_id),
    .xcpt_handler_pc     (xcpt_handler_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [67:0] mk(input logic [31:0] a,
                                     input logic [31:0] p,
                                     input logic [2:0] t);
    return {1'b1, a, p, t};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wb_clr();
    alu_wb_valid = 0; mul_wb_valid = 0; cache_wb_valid = 0;
    alu_rob_id = 0; mul_rob_id = 0; cache_rob_id = 0;
    alu_rob_xcpt_info = '0; mul_rob_xcpt_info = '0;
    cache_rob_xcpt_info = '0;
  endtask

  initial begin
    reset = 1; xcpt_ack = 0;
    rob_head_valid = 0; rob_head_id = 0;
    wb_clr();
    #12;
    chk("rst_valid", 32'(xcpt_valid), 32'd0);
    chk("rst_flush", 32'(xcpt_flush), 32'd0);
    chk("rst_type", 32'(xcpt_type), 32'd0);
    chk("rst_hpc", xcpt_handler_pc, 32'h0000_2000);
    step();
    reset = 0;

    // single ALU overflow id 3
    alu_wb_valid = 1; alu_rob_id = 3;
    alu_rob_xcpt_info = mk(32'hA0A0_0003, 32'h0000_1230, 3'b011);
    #1;
    chk("t1_blk_idle", 32'(rob_retire_block), 32'd0);
    step();
    wb_clr();
    chk("t1_id", 32'(xcpt_rob_id), 32'd3);
    chk("t1_type", 32'(xcpt_type), 32'd3);
    chk("t1_pc", xcpt_pc, 32'h0000_1230);
    chk("t1_valid_pend", 32'(xcpt_valid), 32'd0);
    rob_head_id = 3; rob_head_valid = 1;
    #1;
    chk("t1_blk", 32'(rob_retire_block), 32'd1);
    chk("t1_noflush", 32'(xcpt_flush), 32'd0);
    step();
    chk("t1_flush", 32'(xcpt_flush), 32'd1);
    chk("t1_valid", 32'(xcpt_valid), 32'd1);
    rob_head_valid = 0;
    step();
    chk("t1_flush_once", 32'(xcpt_flush), 32'd0);
    chk("t1_hold_valid", 32'(xcpt_valid), 32'd1);
    chk("t1_hold_type", 32'(xcpt_type), 32'd3);
    xcpt_ack = 1;
    step();
    xcpt_ack = 0;
    chk("t1_idle_valid", 32'(xcpt_valid), 32'd0);
    chk("t1_idle_id", 32'(xcpt_rob_id), 32'd0);
    chk("t1_idle_pc", xcpt_pc, 32'd0);

    // mul id 5 and cache id 2 together, head 0
    rob_head_id = 0;
    mul_wb_valid = 1; mul_rob_id = 5;
    mul_rob_xcpt_info = mk(32'h5555_0000, 32'h500, 3'b010);
    cache_wb_valid = 1; cache_rob_id = 2;
    cache_rob_xcpt_info = mk(32'hCAFE_0002, 32'h200, 3'b100);
    step();
    wb_clr();
    chk("t2_id", 32'(xcpt_rob_id), 32'd2);
    chk("t2_type", 32'(xcpt_type), 32'd4);
    chk("t2_addr", xcpt_addr, 32'hCAFE_0002);
    rob_head_id = 2; rob_head_valid = 1;
    step();
    rob_head_valid = 0;
    chk("t2_flush", 32'(xcpt_flush), 32'd1);
    xcpt_ack = 1;
    step();
    xcpt_ack = 0;
    chk("t2_ack_in_flush", 32'(xcpt_valid), 32'd0);

    // wrap-around ages with head 6
    rob_head_id = 6;
    alu_wb_valid = 1; alu_rob_id = 1;
    alu_rob_xcpt_info = mk(32'h1, 32'h100, 3'b011);
    step();
    wb_clr();
    chk("t3_first", 32'(xcpt_rob_id), 32'd1);
    alu_wb_valid = 1; alu_rob_id = 7;
    alu_rob_xcpt_info = mk(32'h7, 32'h700, 3'b010);
    step();
    wb_clr();
    chk("t3_replace", 32'(xcpt_rob_id), 32'd7);
    chk("t3_replace_pc", xcpt_pc, 32'h700);
    cache_wb_valid = 1; cache_rob_id = 0;
    cache_rob_xcpt_info = mk(32'h0, 32'h0AA, 3'b110);
    step();
    wb_clr();
    chk("t3_keep", 32'(xcpt_rob_id), 32'd7);

    // candidates ignored in FLUSH and WAIT_ACK
    rob_head_id = 7; rob_head_valid = 1;
    step();
    rob_head_valid = 0;
    chk("t4_flush", 32'(xcpt_flush), 32'd1);
    alu_wb_valid = 1; alu_rob_id = 4;
    alu_rob_xcpt_info = mk(32'h4, 32'h400, 3'b011);
    step();
    wb_clr();
    chk("t4_wait_id", 32'(xcpt_rob_id), 32'd7);
    mul_wb_valid = 1; mul_rob_id = 4;
    mul_rob_xcpt_info = mk(32'h4, 32'h404, 3'b010);
    step();
    chk("t4_wait_pc", xcpt_pc, 32'h700);
    xcpt_ack = 1;
    step();
    xcpt_ack = 0;
    wb_clr();
    chk("t4_idle_valid", 32'(xcpt_valid), 32'd0);
    chk("t4_idle_id", 32'(xcpt_rob_id), 32'd0);
    step();
    chk("t4_stay_idle", 32'(xcpt_valid), 32'd0);

    // reset mid WAIT_ACK
    rob_head_id = 0;
    alu_wb_valid = 1; alu_rob_id = 2;
    alu_rob_xcpt_info = mk(32'h22, 32'h220, 3'b011);
    step();
    wb_clr();
    rob_head_id = 2; rob_head_valid = 1;
    step();
    rob_head_valid = 0;
    step();
    chk("t5_wait", 32'(xcpt_valid), 32'd1);
    chk("t5_wait_blk", 32'(rob_retire_block), 32'd1);
    #2;
    reset = 1;
    #1;
    chk("t5_rst_valid", 32'(xcpt_valid), 32'd0);
    chk("t5_rst_id", 32'(xcpt_rob_id), 32'd0);
    chk("t5_rst_pc", xcpt_pc, 32'd0);
    chk("t5_rst_hpc", xcpt_handler_pc, 32'h0000_2000);
    step();
    reset = 0;
    step();
    chk("t5_no_flush", 32'(xcpt_flush), 32'd0);
    step();
    chk("t5_no_valid", 32'(xcpt_valid), 32'd0);

    // candidate at the head
    rob_head_id = 5; rob_head_valid = 1;
    cache_wb_valid = 1; cache_rob_id = 5;
    cache_rob_xcpt_info = mk(32'h55, 32'h550, 3'b101);
    #1;
    chk("t6_blk_same", 32'(rob_retire_block), 32'd1);
    step();
    wb_clr();
    chk("t6_no_flush_yet", 32'(xcpt_flush), 32'd0);
    chk("t6_type", 32'(xcpt_type), 32'd5);
    step();
    chk("t6_flush", 32'(xcpt_flush), 32'd1);
    rob_head_valid = 0;
    xcpt_ack = 1;
    step();
    xcpt_ack = 0;
    chk("t6_idle", 32'(xcpt_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
